// File: rtl/main_memory_responder.sv
// Single-port word memory that answers burst (fixed BURST_LEN) and stream (open-ended)
// read/write transactions from one initiator, with a one-cycle GAP after each completed transfer.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module main_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_rw,
  input  logic                  mem_op_size,
  input  logic                  mem_finishes_op,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_write_req,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  output logic                  mem_last
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_BEAT, WR_BEAT, GAP} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [ADDR_WIDTH-1:0]   start_idx;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    stream_mode;
  logic                    beat_active;
  logic                    rd_en;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign word_idx  = mem_addr[ADDR_WIDTH+1:2];
  assign start_idx = mem_op_size ? word_idx
                                 : {word_idx[ADDR_WIDTH-1:CNT_W], {CNT_W{1'b0}}};

  // Byte-lane and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // Beats are gated by mem_enable so an abort silences outputs in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    beat_active    = 1'b0;
    mem_read_valid = 1'b0;
    mem_write_req  = 1'b0;
    mem_last       = 1'b0;
    mem_read       = '0;

    if (mem_enable) begin
      mem_read_valid = (state == RD_BEAT);
      mem_write_req  = (state == WR_BEAT);
      beat_active    = mem_read_valid || mem_write_req;
      mem_last       = beat_active &&
                       (stream_mode ? mem_finishes_op
                                    : (beat_cnt == CNT_W'(BURST_LEN - 1)));
    end
    if (mem_read_valid) mem_read = rd_data;

    unique case (state)
      IDLE:     if (mem_enable) state_nxt = (mem_rw == `MEM_READ) ? RD_SETUP : WR_BEAT;
      RD_SETUP: state_nxt = mem_enable ? RD_BEAT : IDLE;
      RD_BEAT,
      WR_BEAT:  if (!mem_enable) state_nxt = IDLE;
                else if (mem_last) state_nxt = GAP;
      GAP:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      addr        <= '0;
      stream_mode <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        addr        <= start_idx;
        beat_cnt    <= '0;
        stream_mode <= mem_op_size;
      end else if (state == RD_SETUP || beat_active) begin
        addr <= addr + ADDR_WIDTH'(1);
        if (beat_active) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Read address is issued one beat ahead, so RD_BEAT always sees the current word registered.
  assign rd_en = (state == RD_SETUP) || (state == RD_BEAT);
  assign wr_en = mem_write_req && !rst;

  // NOTE: the array and its read register carry no reset; contents survive rst and only
  // mem_read (masked by mem_read_valid) must read as zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= mem_write;
    if (rd_en) rd_data   <= mem[addr];
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: table of transactions checked beat by beat
// against a shadow memory, plus hand-written reset-during-transfer sequences.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module tb_main_memory_responder;
  localparam int DW = 32;
  localparam int AW = 14;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_enable;
  logic [31:0]   mem_addr;
  logic          mem_rw;
  logic          mem_op_size;
  logic          mem_finishes_op;
  logic [DW-1:0] mem_write;
  logic          mem_write_req;
  logic [DW-1:0] mem_read;
  logic          mem_read_valid;
  logic          mem_last;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] ref_mem [1 << AW];

  typedef struct {
    logic        rw;
    logic        op_size;
    logic [31:0] addr;
    int          nbeats;
    int          abort_after;
    logic        hold;
    logic [31:0] data_base;
  } txn_t;

  txn_t tbl [9];

  main_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_enable      (mem_enable),
    .mem_addr        (mem_addr),
    .mem_rw          (mem_rw),
    .mem_op_size     (mem_op_size),
    .mem_finishes_op (mem_finishes_op),
    .mem_write       (mem_write),
    .mem_write_req   (mem_write_req),
    .mem_read        (mem_read),
    .mem_read_valid  (mem_read_valid),
    .mem_last        (mem_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, mem_read_valid, 1'b0);
    check({name, "_req"},   mem_write_req,  1'b0);
    check({name, "_last"},  mem_last,       1'b0);
    check({name, "_data"},  mem_read,       '0);
  endtask

  // Starts from IDLE; inputs change on negedge and outputs are sampled 1 ns later.
  task automatic run_txn(input txn_t t);
    int base_idx;
    int idx;
    @(negedge clk);
    mem_enable      = 1'b1;
    mem_addr        = t.addr;
    mem_rw          = t.rw;
    mem_op_size     = t.op_size;
    mem_finishes_op = 1'b0;
    #1 check_quiet("idle");
    if (t.rw == `MEM_READ) begin
      @(negedge clk);
      #1 check_quiet("rd_setup");
    end
    base_idx = int'(t.addr >> 2) & ((1 << AW) - 1);
    if (!t.op_size) base_idx = base_idx & ~(BL - 1);
    for (int b = 1; b <= t.nbeats; b++) begin
      @(negedge clk);
      idx             = (base_idx + b - 1) & ((1 << AW) - 1);
      mem_write       = t.data_base + 32'(b - 1);
      mem_finishes_op = t.op_size && (b == t.nbeats);
      if (t.abort_after != 0 && b > t.abort_after) begin
        mem_enable = 1'b0;
        #1 check_quiet("abort");
        @(negedge clk);
        #1 check_quiet("after_abort");
        return;
      end
      #1;
      if (t.rw == `MEM_READ) begin
        check("rd_valid", mem_read_valid, 1'b1);
        check("rd_req",   mem_write_req,  1'b0);
        check("rd_data",  mem_read,       ref_mem[idx]);
      end else begin
        check("wr_req",   mem_write_req,  1'b1);
        check("wr_valid", mem_read_valid, 1'b0);
        check("wr_rdata", mem_read,       '0);
        ref_mem[idx] = mem_write;
      end
      check("last", mem_last, (b == t.nbeats));
    end
    @(negedge clk);
    mem_enable      = t.hold;
    mem_finishes_op = 1'b0;
    #1 check_quiet("gap");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_enable = 1'b0; mem_addr = '0; mem_rw = `MEM_READ;
    mem_op_size = 1'b0; mem_finishes_op = 1'b0; mem_write = '0;

    tbl[0] = '{`MEM_WRITE, 1'b0, 32'h0000_0024, 8, 0, 1'b0, 32'h100}; // words 8..15
    tbl[1] = '{`MEM_READ,  1'b0, 32'h0000_0020, 8, 0, 1'b0, 32'h0};
    tbl[2] = '{`MEM_WRITE, 1'b1, 32'h0000_FFF8, 3, 0, 1'b0, 32'h500}; // 3FFE,3FFF,0000
    tbl[3] = '{`MEM_READ,  1'b1, 32'h0001_FFFB, 3, 0, 1'b0, 32'h0};   // junk high/low bits
    tbl[4] = '{`MEM_READ,  1'b1, 32'h0000_FFF8, 1, 0, 1'b0, 32'h0};
    tbl[5] = '{`MEM_WRITE, 1'b0, 32'h0000_0040, 8, 0, 1'b0, 32'h200}; // words 16..23
    tbl[6] = '{`MEM_WRITE, 1'b0, 32'h0000_0044, 8, 3, 1'b0, 32'h300}; // aborted after 3
    tbl[7] = '{`MEM_READ,  1'b0, 32'h0000_005C, 8, 0, 1'b1, 32'h0};   // enable held in GAP
    tbl[8] = '{`MEM_READ,  1'b0, 32'h0000_0024, 8, 0, 1'b0, 32'h0};

    // Reset state, with enable high so a stuck state machine would show beats.
    repeat (2) @(negedge clk);
    mem_enable = 1'b1;
    #1 check_quiet("in_reset");
    @(negedge clk);
    rst = 1'b0;
    mem_enable = 1'b0;
    #1 check_quiet("post_reset");

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Reset after two beats of a read burst.
    @(negedge clk);
    mem_enable = 1'b1; mem_addr = 32'h20; mem_rw = `MEM_READ; mem_op_size = 1'b0;
    @(negedge clk);
    @(negedge clk); #1 check("rst_rd_b1", mem_read, ref_mem[8]);
    @(negedge clk); #1 check("rst_rd_b2", mem_read, ref_mem[9]);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check_quiet("rd_reset");
    mem_enable = 1'b0;
    run_txn('{`MEM_READ, 1'b0, 32'h0000_0020, 8, 0, 1'b0, 32'h0});

    // Reset on the second beat of a write burst: that beat must not land.
    @(negedge clk);
    mem_enable = 1'b1; mem_addr = 32'h40; mem_rw = `MEM_WRITE; mem_op_size = 1'b0;
    @(negedge clk); mem_write = 32'h900; ref_mem[16] = 32'h900;
    #1 check("rst_wr_b1", mem_write_req, 1'b1);
    @(negedge clk); mem_write = 32'h901; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check_quiet("wr_reset");
    mem_enable = 1'b0;
    check("wr_keep_ref", ref_mem[17], 32'h301);
    run_txn('{`MEM_READ, 1'b0, 32'h0000_0040, 8, 0, 1'b0, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
